argmax_scheduler: RTL and testbench

- Sequences the final classification stage: accepts one packed class-score vector from the last conv/pool layer, scans it serially, and returns the winning class index.
- Uses a valid/ready handshake on both sides, so upstream layers can stall and downstream result consumers (UART/LED/testbench sink) can apply backpressure.
- Holds one vector at a time and counts completed classifications.

---
 rtl/argmax_scheduler.sv | 136 +++++++++++++
 tb/tb_argmax_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/argmax_scheduler.sv
// argmax_scheduler
//   Final classification stage. Accepts one packed class-score vector,
//   scans it one score per cycle, and returns the index of the largest
//   score. The lowest index wins on ties. Counts completed hand-offs.
//
// Ports
//   clk, rst          clock / synchronous active-high reset
//   in_scores         packed scores, class k at [k*BIT_SIZE +: BIT_SIZE]
//   in_valid/in_ready input handshake (ready only in IDLE)
//   out_class         winning class index
//   out_valid/out_ready result handshake (valid only in DONE)
//   busy              high while a vector is held (SCAN or DONE)
//   frame_count       results handed off, wraps at 2^CNT_WIDTH
//   out_score         winning score (only with ARGMAX_SCORE_OUT_EN)
//
// Optional build macro: ARGMAX_SCORE_OUT_EN adds the out_score port.
module argmax_scheduler #(
  parameter int BIT_SIZE    = 8,
  parameter int NUM_CLASSES = 10,
  parameter int CNT_WIDTH   = 16,
  localparam int IW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BIT_SIZE*NUM_CLASSES-1:0] in_scores,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [IW-1:0]                   out_class,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
`ifdef ARGMAX_SCORE_OUT_EN
  output logic [BIT_SIZE-1:0]             out_score,
`endif
  output logic [CNT_WIDTH-1:0]            frame_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IW-1:0] LAST = IW'(NUM_CLASSES - 1);

  state_t state_q, state_d;

  logic [NUM_CLASSES-1:0][BIT_SIZE-1:0] scores_q;
  logic [BIT_SIZE-1:0]                  max_q;
  logic [IW-1:0]                        idx_q;
  logic [IW-1:0]                        cnt_q;
  logic [IW-1:0]                        class_q;
  logic [CNT_WIDTH-1:0]                 frame_q;
  logic [BIT_SIZE-1:0]                  cur_score;
  logic                                 better;
  logic                                 last;

  // Scan compare: strict greater-than keeps the earliest index on ties.
  assign cur_score = scores_q[cnt_q];
  assign better    = cur_score > max_q;
  assign last      = (cnt_q == LAST);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (NUM_CLASSES == 1) ? DONE : SCAN;
      SCAN: if (last)      state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // outputs, decoded from registered state only
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
  end

  assign out_class   = class_q;
  assign frame_count = frame_q;

  // datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      scores_q <= '0;
      max_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      class_q  <= '0;
      frame_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          scores_q <= in_scores;
          max_q    <= in_scores[BIT_SIZE-1:0];
          idx_q    <= '0;
          cnt_q    <= IW'(1);
          if (NUM_CLASSES == 1) class_q <= '0;
        end
        SCAN: begin
          if (better) begin
            max_q <= cur_score;
            idx_q <= cnt_q;
          end
          // final result must include this cycle's compare
          if (last) class_q <= better ? cnt_q : idx_q;
          else      cnt_q   <= cnt_q + IW'(1);
        end
        DONE: if (out_ready) frame_q <= frame_q + CNT_WIDTH'(1);
        default: ;
      endcase
    end
  end

`ifdef ARGMAX_SCORE_OUT_EN
  logic [BIT_SIZE-1:0] score_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= '0;
    end else begin
      if (state_q == IDLE && in_valid && NUM_CLASSES == 1)
        score_q <= in_scores[BIT_SIZE-1:0];
      else if (state_q == SCAN && last)
        score_q <= better ? cur_score : max_q;
    end
  end

  assign out_score = score_q;
`endif

endmodule

// File: tb/tb_argmax_scheduler.sv
module tb_argmax_scheduler;
  localparam int BS = 8;
  localparam int NC = 10;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [BS*NC-1:0] in_scores;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     out_class;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  logic [CW-1:0]  frame_count;
`ifdef ARGMAX_SCORE_OUT_EN
  logic [BS-1:0]  out_score;
`endif

  int checks   = 0;
  int failures = 0;

  argmax_scheduler #(.BIT_SIZE(BS), .NUM_CLASSES(NC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_scores(in_scores), .in_valid(in_valid),
    .in_ready(in_ready), .out_class(out_class), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy),
`ifdef ARGMAX_SCORE_OUT_EN
    .out_score(out_score),
`endif
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [BS*NC-1:0] mkvec(input logic [7:0] fill,
      input int k1, input logic [7:0] v1, input int k2, input logic [7:0] v2);
    logic [BS*NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i*BS +: BS] = fill;
    if (k1 >= 0) v[k1*BS +: BS] = v1;
    if (k2 >= 0) v[k2*BS +: BS] = v2;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a vector while IDLE, then wait (bounded) for out_valid.
  // lat = edges after the accept edge until out_valid, -1 on timeout.
  task automatic run_vec(input logic [BS*NC-1:0] vec, output int lat,
                         output logic [3:0] cls);
    in_scores = vec;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_scores = '1;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    cls = out_class;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_scores = '0;
    tick(); tick();
    rst = 1'b0;
    checks += 5;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_class !== 4'd0) begin failures++; $display("FAIL reset_out_class got=%0d exp=0", out_class); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (frame_count !== 16'd0) begin failures++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
  endtask

  task automatic test_basic();
    int lat; logic [3:0] cls;
    run_vec(mkvec(8'd10, 3, 8'd200, -1, 8'd0), lat, cls);
    checks += 6;
    if (lat !== 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    if (cls !== 4'd3) begin failures++; $display("FAIL basic_class got=%0d exp=3", cls); end
    if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_done_flags got=%b%b exp=01", in_ready, busy); end
    handshake();
    if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_after_hs_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_after_hs_ready got=%b exp=1", in_ready); end
    if (frame_count !== 16'd1) begin failures++; $display("FAIL basic_frame_count got=%0d exp=1", frame_count); end
  endtask

  task automatic test_tie();
    int lat; logic [3:0] cls;
    run_vec(mkvec(8'd0, 2, 8'd255, 7, 8'd255), lat, cls);
    checks++;
    if (cls !== 4'd2) begin failures++; $display("FAIL tie_class got=%0d exp=2", cls); end
    handshake();
    run_vec(mkvec(8'd0, -1, 8'd0, -1, 8'd0), lat, cls);
    checks++;
    if (cls !== 4'd0) begin failures++; $display("FAIL zero_class got=%0d exp=0", cls); end
    handshake();
    run_vec(mkvec(8'd77, -1, 8'd0, -1, 8'd0), lat, cls);
    checks++;
    if (cls !== 4'd0) begin failures++; $display("FAIL equal_class got=%0d exp=0", cls); end
    handshake();
    run_vec(mkvec(8'd5, 9, 8'd6, -1, 8'd0), lat, cls);
    checks += 2;
    if (cls !== 4'd9) begin failures++; $display("FAIL last_class got=%0d exp=9", cls); end
    handshake();
    if (frame_count !== 16'd5) begin failures++; $display("FAIL tie_frame_count got=%0d exp=5", frame_count); end
  endtask

  task automatic test_backpressure();
    int lat; logic [3:0] cls;
    run_vec(mkvec(8'd1, 4, 8'd99, -1, 8'd0), lat, cls);
    checks++;
    if (cls !== 4'd4) begin failures++; $display("FAIL bp_class got=%0d exp=4", cls); end
    for (int i = 0; i < 20; i++) begin
      in_valid  = i[0];
      in_scores = mkvec(8'd0, 8, 8'd250, -1, 8'd0);
      tick();
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid); end
      if (out_class !== 4'd4) begin failures++; $display("FAIL bp_class_hold cyc=%0d got=%0d exp=4", i, out_class); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
    end
    in_valid = 1'b0;
    handshake();
    checks += 3;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    if (frame_count !== 16'd6) begin failures++; $display("FAIL bp_frame_count got=%0d exp=6", frame_count); end
  endtask

  task automatic test_back_to_back();
    int acc[2]; int res[2]; int n_acc = 0; int n_res = 0;
    acc[0] = -100; acc[1] = -100; res[0] = -1; res[1] = -1;
    rst = 1'b1; tick(); rst = 1'b0;
    in_scores = mkvec(8'd3, 9, 8'd40, -1, 8'd0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 60 && n_res < 2; t++) begin
      if (out_valid) begin res[n_res] = int'(out_class); n_res++; end
      if (in_ready && n_acc < 2) begin acc[n_acc] = t; n_acc++; end
      tick();
      if (n_acc == 1) in_scores = mkvec(8'd3, 0, 8'd40, -1, 8'd0);
      if (n_acc == 2) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    checks += 5;
    if (res[0] !== 9) begin failures++; $display("FAIL b2b_first got=%0d exp=9", res[0]); end
    if (res[1] !== 0) begin failures++; $display("FAIL b2b_second got=%0d exp=0", res[1]); end
    if (acc[1] - acc[0] !== 11) begin failures++; $display("FAIL b2b_spacing got=%0d exp=11", acc[1] - acc[0]); end
    if (frame_count !== 16'd2) begin failures++; $display("FAIL b2b_frame_count got=%0d exp=2", frame_count); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid_scan();
    int lat; logic [3:0] cls; int seen = 0;
    in_scores = mkvec(8'd0, 1, 8'd90, -1, 8'd0);
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();  // scan cycle 4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 4;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_scan_ready got=%b exp=1", in_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_scan_busy got=%b exp=0", busy); end
    if (frame_count !== 16'd0) begin failures++; $display("FAIL rst_scan_frame got=%0d exp=0", frame_count); end
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      tick();
    end
    if (seen !== 0) begin failures++; $display("FAIL rst_scan_no_valid got=%0d exp=0", seen); end
    run_vec(mkvec(8'd12, 5, 8'd31, 2, 8'd30), lat, cls);
    checks += 3;
    if (lat !== 9) begin failures++; $display("FAIL rst_scan_latency got=%0d exp=9", lat); end
    if (cls !== 4'd5) begin failures++; $display("FAIL rst_scan_class got=%0d exp=5", cls); end
    handshake();
    if (frame_count !== 16'd1) begin failures++; $display("FAIL rst_scan_frame_after got=%0d exp=1", frame_count); end
  endtask

`ifdef ARGMAX_SCORE_OUT_EN
  task automatic test_score_out();
    int lat; logic [3:0] cls;
    run_vec(mkvec(8'd20, 6, 8'd173, 2, 8'd172), lat, cls);
    checks += 2;
    if (cls !== 4'd6) begin failures++; $display("FAIL score_class got=%0d exp=6", cls); end
    if (out_score !== 8'd173) begin failures++; $display("FAIL score_value got=%0d exp=173", out_score); end
    handshake();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_scan();
`ifdef ARGMAX_SCORE_OUT_EN
    test_score_out();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
